// File: rtl/button_pio_pkg.sv
// Shared constants for the debounced push-button PIO: register addresses and edge selection.
package button_pio_pkg;

  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_PERIOD  = 2'd1;
  localparam logic [1:0] ADDR_MASK    = 2'd2;
  localparam logic [1:0] ADDR_CAPTURE = 2'd3;

  typedef enum logic [1:0] {
    EDGE_RISE = 2'd0,
    EDGE_FALL = 2'd1,
    EDGE_ANY  = 2'd2
  } edge_type_e;

  function automatic logic edge_select(input int edge_type, input logic rise, input logic fall);
    logic sel;
    case (edge_type)
      int'(EDGE_RISE): sel = rise;
      int'(EDGE_FALL): sel = fall;
      default:         sel = rise | fall;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/button_debounce_ch.sv
// One button channel: 2-FF synchroniser, programmable debounce counter, stable level and edge pulse.
module button_debounce_ch
  import button_pio_pkg::*;
#(
  parameter int                  DB_CNT_W   = 20,
  parameter int                  EDGE_TYPE  = 1,
  parameter logic                IDLE_LEVEL = 1'b1
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [DB_CNT_W-1:0] period,
  input  logic                raw_in,
  output logic                stable,
  output logic                edge_pulse
);

  logic                sync1_reg;
  logic                sync2_reg;
  logic                stable_reg;
  logic                stable_d_reg;
  logic [DB_CNT_W-1:0] cnt_reg;
  logic                accept;

  // Periods of 0 and 1 both mean "follow the synchroniser"; the >= compare lets a
  // shortened period take effect on a count already in progress.
  assign accept = (period <= DB_CNT_W'(1)) || (cnt_reg >= period - DB_CNT_W'(1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_reg    <= IDLE_LEVEL;
      sync2_reg    <= IDLE_LEVEL;
      stable_reg   <= IDLE_LEVEL;
      stable_d_reg <= IDLE_LEVEL;
      cnt_reg      <= '0;
    end else begin
      sync1_reg    <= raw_in;
      sync2_reg    <= sync1_reg;
      stable_d_reg <= stable_reg;
      if (sync2_reg == stable_reg) begin
        cnt_reg <= '0;
      end else if (accept) begin
        stable_reg <= sync2_reg;
        cnt_reg    <= '0;
      end else begin
        cnt_reg <= cnt_reg + DB_CNT_W'(1);
      end
    end
  end

  assign stable     = stable_reg;
  assign edge_pulse = edge_select(EDGE_TYPE, stable_reg & ~stable_d_reg, ~stable_reg & stable_d_reg);

endmodule

// File: rtl/button_pio_debounced.sv
// Avalon-MM push-button port: per-channel debounce, edge capture (W1C), masked level interrupt.
module button_pio_debounced
  import button_pio_pkg::*;
#(
  parameter int                  WIDTH      = 4,
  parameter int                  DB_CNT_W   = 20,
  parameter logic [DB_CNT_W-1:0] DB_DEFAULT = 20'd500000,
  parameter int                  EDGE_TYPE  = 1,
  parameter logic                IDLE_LEVEL = 1'b1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  logic [DB_CNT_W-1:0] period_reg;
  logic [WIDTH-1:0]    mask_reg;
  logic [WIDTH-1:0]    capture_reg;
  logic [WIDTH-1:0]    capture_next;
  logic [WIDTH-1:0]    clear_vec;
  logic [WIDTH-1:0]    stable_vec;
  logic [WIDTH-1:0]    edge_vec;
  logic                irq_reg;
  logic [31:0]         readdata_reg;
  logic [31:0]         readdata_next;
  logic                wr_en;
  logic                writedata_unused;

  assign wr_en            = chipselect & ~write_n;
  assign writedata_unused = ^writedata;

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_ch
    button_debounce_ch #(
      .DB_CNT_W  (DB_CNT_W),
      .EDGE_TYPE (EDGE_TYPE),
      .IDLE_LEVEL(IDLE_LEVEL)
    ) u_ch (
      .clk       (clk),
      .reset_n   (reset_n),
      .period    (period_reg),
      .raw_in    (in_port[gi]),
      .stable    (stable_vec[gi]),
      .edge_pulse(edge_vec[gi])
    );
  end

  // A new edge is OR-ed in after the clear so a coincident W1C cannot lose it.
  always_comb begin
    clear_vec = '0;
    if (wr_en && address == ADDR_CAPTURE) begin
      clear_vec = writedata[WIDTH-1:0];
    end
    capture_next = (capture_reg & ~clear_vec) | edge_vec;
  end

  always_comb begin
    readdata_next = '0;
    case (address)
      ADDR_DATA:    readdata_next = 32'(stable_vec);
      ADDR_PERIOD:  readdata_next = 32'(period_reg);
      ADDR_MASK:    readdata_next = 32'(mask_reg);
      ADDR_CAPTURE: readdata_next = 32'(capture_reg);
      default:      readdata_next = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      period_reg   <= DB_DEFAULT;
      mask_reg     <= '0;
      capture_reg  <= '0;
      irq_reg      <= 1'b0;
      readdata_reg <= '0;
    end else begin
      if (wr_en && address == ADDR_PERIOD) begin
        period_reg <= writedata[DB_CNT_W-1:0];
      end
      if (wr_en && address == ADDR_MASK) begin
        mask_reg <= writedata[WIDTH-1:0];
      end
      capture_reg  <= capture_next;
      irq_reg      <= |(capture_reg & mask_reg);
      readdata_reg <= readdata_next;
    end
  end

  assign readdata = readdata_reg;
  assign irq      = irq_reg;

endmodule

// File: tb/tb_button_pio_debounced.sv
// Directed bench for button_pio_debounced with a history-based reference model checked every cycle.
module tb_button_pio_debounced;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [3:0]  in_port;
  logic        irq;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  button_pio_debounced dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .address   (address),
    .chipselect(chipselect),
    .write_n   (write_n),
    .writedata (writedata),
    .readdata  (readdata),
    .in_port   (in_port),
    .irq       (irq)
  );

  // Reference model: a level is accepted once the trailing run of synchronised
  // samples that disagree with the accepted level is at least PERIOD long.
  logic [3:0]  m_s1, m_s2, m_stable, m_stable_d, m_cap, m_mask;
  logic [19:0] m_period;
  logic        m_irq;
  logic [31:0] m_rd;
  logic [3:0]  hist[$];

  always @(posedge clk or negedge reset_n) begin
    logic [31:0] rd_n;
    logic [3:0]  clr, edges, cap_n, stable_n;
    int          need, run;
    if (!reset_n) begin
      m_s1 = 4'hF; m_s2 = 4'hF; m_stable = 4'hF; m_stable_d = 4'hF;
      m_cap = 4'h0; m_mask = 4'h0; m_period = 20'd500000; m_irq = 1'b0; m_rd = 32'h0;
      hist.delete();
    end else begin
      case (address)
        2'd0:    rd_n = {28'h0, m_stable};
        2'd1:    rd_n = {12'h0, m_period};
        2'd2:    rd_n = {28'h0, m_mask};
        default: rd_n = {28'h0, m_cap};
      endcase
      clr   = (chipselect && !write_n && address == 2'd3) ? writedata[3:0] : 4'h0;
      edges = ~m_stable & m_stable_d;
      cap_n = (m_cap & ~clr) | edges;
      hist.push_back(m_s2);
      if (hist.size() > 1024) void'(hist.pop_front());
      need = (m_period <= 20'd1) ? 1 : int'(m_period);
      stable_n = m_stable;
      for (int ch = 0; ch < 4; ch++) begin
        run = 0;
        for (int k = hist.size() - 1; k >= 0; k--) begin
          if (hist[k][ch] == m_stable[ch]) break;
          run++;
        end
        if (run >= need) stable_n[ch] = ~m_stable[ch];
      end
      m_irq      = |(m_cap & m_mask);
      m_rd       = rd_n;
      m_cap      = cap_n;
      m_stable_d = m_stable;
      m_stable   = stable_n;
      m_s2       = m_s1;
      m_s1       = in_port;
      if (chipselect && !write_n && address == 2'd1) m_period = writedata[19:0];
      if (chipselect && !write_n && address == 2'd2) m_mask = writedata[3:0];
    end
  end

  always @(negedge clk) begin
    if (reset_n === 1'b1) begin
      n_tests++;
      if (readdata !== m_rd) begin
        n_fail++;
        $display("FAIL cycle_readdata t=%0t actual=%h required=%h", $time, readdata, m_rd);
      end
      n_tests++;
      if (irq !== m_irq) begin
        n_fail++;
        $display("FAIL cycle_irq t=%0t actual=%b required=%b", $time, irq, m_irq);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end else begin
      $display("[TB] ok %s = %0h", name, act);
    end
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    @(negedge clk);
    address = a;
    @(negedge clk);
    d = readdata;
  endtask

  initial begin
    logic [31:0] d;
    int highs;
    reset_n = 1'b0; chipselect = 1'b0; write_n = 1'b1; address = 2'd0;
    writedata = 32'h0; in_port = 4'hF;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;

    // Reset state
    highs = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (irq) highs++;
    end
    check("irq_idle_100_cycles", 32'(highs), 32'd0);
    bus_read(2'd0, d); check("rst_data", d, 32'hF);
    bus_read(2'd1, d); check("rst_period", d, 32'd500000);
    bus_read(2'd2, d); check("rst_mask", d, 32'h0);
    bus_read(2'd3, d); check("rst_capture", d, 32'h0);

    // Clean falling level on channel 2 with PERIOD=8
    bus_write(2'd1, 32'd8);
    bus_read(2'd1, d); check("period_8", d, 32'd8);
    @(negedge clk); in_port[2] = 1'b0; address = 2'd0;
    for (int k = 1; k <= 11; k++) begin
      @(negedge clk);
      if (k == 10) check("data2_at_10", 32'(readdata[2]), 32'd1);
      if (k == 11) check("data2_at_11", 32'(readdata[2]), 32'd0);
    end
    bus_read(2'd3, d); check("capture_ch2", d, 32'h4);
    check("irq_masked_off", 32'(irq), 32'd0);
    bus_write(2'd2, 32'h4);
    check("irq_mask_same_cycle", 32'(irq), 32'd0);
    @(negedge clk); check("irq_after_mask", 32'(irq), 32'd1);
    in_port[2] = 1'b1;
    repeat (12) @(negedge clk);
    bus_write(2'd3, 32'hF);
    @(negedge clk); check("irq_after_clear", 32'(irq), 32'd0);
    bus_read(2'd3, d); check("capture_rise_ignored", d, 32'h0);

    // Bouncing channel 0: low 5, high 1, then low
    @(negedge clk); in_port[0] = 1'b0; address = 2'd0;
    repeat (4) @(negedge clk);
    @(negedge clk); in_port[0] = 1'b1;
    @(negedge clk); in_port[0] = 1'b0;
    for (int k = 1; k <= 11; k++) begin
      @(negedge clk);
      if (k == 10) check("bounce_data0_at_10", 32'(readdata[0]), 32'd1);
      if (k == 11) check("bounce_data0_at_11", 32'(readdata[0]), 32'd0);
    end
    bus_read(2'd3, d); check("bounce_single_capture", d, 32'h1);
    bus_write(2'd3, 32'h1);
    in_port[0] = 1'b1;
    repeat (12) @(negedge clk);

    // W1C colliding with a new edge on bit 2
    @(negedge clk); in_port[2] = 1'b0;
    repeat (9) @(negedge clk);
    bus_write(2'd3, 32'h4);
    repeat (2) @(negedge clk);
    check("collide_irq", 32'(irq), 32'd1);
    bus_read(2'd3, d); check("collide_set_wins", d, 32'h4);
    bus_write(2'd3, 32'h1);
    bus_read(2'd3, d); check("w1c_other_bit", d, 32'h4);
    check("w1c_other_irq", 32'(irq), 32'd1);
    bus_write(2'd2, 32'h0);
    @(negedge clk); check("irq_after_unmask", 32'(irq), 32'd0);
    bus_write(2'd3, 32'h4);
    in_port[2] = 1'b1;
    repeat (12) @(negedge clk);

    // Reset in the middle of a count
    bus_write(2'd2, 32'h2);
    @(negedge clk); in_port[1] = 1'b0;
    repeat (7) @(negedge clk);
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    bus_read(2'd0, d); check("midrst_data", d, 32'hF);
    bus_read(2'd1, d); check("midrst_period", d, 32'd500000);
    bus_read(2'd2, d); check("midrst_mask", d, 32'h0);
    repeat (20) @(negedge clk);
    bus_read(2'd3, d); check("midrst_no_capture", d, 32'h0);
    bus_read(2'd0, d); check("midrst_data_held", d, 32'hF);
    check("midrst_irq", 32'(irq), 32'd0);
    in_port[1] = 1'b1;
    repeat (4) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
